pipe_if_queue: RTL and testbench
================================

// Module: pipe_if_queue
// PURPOSE
//   Parametrised instruction-fetch stage for the pipelined CPU. Holds the fetch PC, drives a
//   synchronous instruction ROM and buffers returned instructions in a DEPTH-entry queue, so
//   decode can stall without re-fetching. Branch/jump redirects from decode flush the queue
//   and any in-flight fetch. Sits between the instruction ROM and the IF/ID register.
// PARAMETERS
//   XLEN      32   data/PC width
//   ADDR_W    6    ROM word-address width (ROM holds 2**ADDR_W words)
//   DEPTH     4    instruction queue entries (power of two, >=2)
//   RESET_PC  0    fetch PC after reset
// PORTS
//   clock      in   1          system clock, all state on rising edge
//   resetn     in   1          asynchronous active-low reset
//   pcsource   in   2          00 sequential, 01 bpc, 10 da, 11 jpc; non-00 = redirect this cycle
//   bpc        in   XLEN       branch target
//   da         in   XLEN       register (jr) target
//   jpc        in   XLEN       jump target
//   stall      in   1          1 = decode does not accept head entry this cycle
//   imem_addr  out  ADDR_W     ROM word address; ROM returns data one clock later
//   imem_data  in   XLEN       ROM read data
//   ins        out  XLEN       head instruction
//   pc4        out  XLEN       head instruction's PC + 4
//   ins_valid  out  1          queue non-empty; head consumed when ins_valid & ~stall
// BEHAVIOUR
//   - Reset (async): fpc=RESET_PC, queue empty, inflight=0; ins=0, pc4=0, ins_valid=0.
//   - imem_addr = fpc[ADDR_W+1:2] combinationally; ROM index wraps modulo 2**ADDR_W.
//   - Issue: when count+inflight < DEPTH and no redirect, fpc <= fpc+4 (wraps mod 2**XLEN),
//     inflight <= 1, and the issued PC+4 is held in a side register. Otherwise fpc holds.
//   - Return: in the cycle after an issue, imem_data plus the held PC+4 are pushed at the
//     next edge. Credit rule guarantees a push never meets a full queue.
//   - Pop: ins_valid & ~stall advances the head at the edge. Push and pop in the same cycle
//     leave count unchanged. The queue is circular; read/write pointers wrap at DEPTH.
//   - Latency: fetch issued in cycle N is visible on ins/ins_valid in cycle N+2 when the queue
//     was empty. Steady state with stall=0 delivers one instruction per cycle.
//   - Redirect (pcsource!=00), top priority:
//       - fpc <= selected target with bits [1:0] forced to 00.
//       - Queue emptied; the in-flight response is killed (not pushed).
//       - No issue in the redirect cycle.
//       - Any same-cycle pop is ignored.
//       - Target fetch issues the next cycle; its instruction is valid 2 cycles later.
//   - Stall with queue full: issue stops, fpc holds, outputs hold stable.
//   - Reset mid-operation: immediate return to reset state, killing in-flight data.
//   - ins/pc4 show the head entry; when empty they hold their last value (ignored by decode).
// TESTING
//   1 ROM[i]=i*0x11; release reset, stall=0 -> ins_valid rises 2 cycles later; ins 0x00,0x11,
//     0x22... one per cycle; pc4 4,8,12...
//   2 stall=1 for 10 cycles from start -> exactly DEPTH(4) fetches issued, fpc=0x10 holds,
//     ins=0x00 stable; release -> 0x00..0x33 then 0x44 with no gap or duplicate.
//   3 pcsource=01, bpc=0x40 while queue has 3 entries -> next cycle ins_valid=0; 2 cycles
//     later ins=ROM[16], pc4=0x44; no stale entry ever appears.
//   4 pcsource=10, da=0x23 -> fetch from 0x20 (low bits cleared); same test with pcsource=11.
//   5 fpc reaches 0xFC with ADDR_W=6 -> next fetch imem_addr=0, pc4=0x104; XLEN wrap: jpc=
//     0xFFFFFFFC -> following pc4=0x00000000.
//   6 resetn low for one cycle during steady streaming -> outputs 0 at once; restart from
//     RESET_PC with the same latency as test 1.

Source files
------------

// File: rtl/pipe_if_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives a synchronous ROM and buffers
// returned instructions in a DEPTH-entry circular queue so decode can stall freely.
module pipe_if_queue #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 6,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        pcsource,
  input  logic [XLEN-1:0]   bpc,
  input  logic [XLEN-1:0]   da,
  input  logic [XLEN-1:0]   jpc,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  output logic [XLEN-1:0]   ins,
  output logic [XLEN-1:0]   pc4,
  output logic              ins_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc4;
  } q_entry_t;

  logic [XLEN-1:0]  fpc;
  logic [XLEN-1:0]  held_pc4;
  logic             inflight;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occ;
  q_entry_t         q_mem [DEPTH];
  q_entry_t         head;
  q_entry_t         last_q;

  logic             redirect;
  logic             issue;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  target;

  assign redirect  = |pcsource;
  assign imem_addr = fpc[ADDR_W+1:2];
  assign ins_valid = (count != '0);
  assign head      = q_mem[rd_ptr];

  // Credit check counts the in-flight fetch, so a returning word always has a slot.
  assign occ   = count + CNT_W'(inflight);
  assign issue = !redirect && (occ < CNT_W'(DEPTH));
  assign push  = inflight && !redirect;
  assign pop   = ins_valid && !stall && !redirect;

  always_comb begin
    target = fpc;
    unique case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = da;
      2'b11:   target = jpc;
      default: target = fpc;
    endcase
  end

  // Empty queue keeps presenting the last head seen rather than a stale slot.
  assign ins = ins_valid ? head.ins : last_q.ins;
  assign pc4 = ins_valid ? head.pc4 : last_q.pc4;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fpc      <= RESET_PC;
      held_pc4 <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_q   <= '0;
    end else begin
      if (redirect) begin
        fpc      <= target & ~XLEN'(3);
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (issue) begin
          fpc      <= fpc + XLEN'(4);
          held_pc4 <= fpc + XLEN'(4);
        end
        inflight <= issue;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      if (ins_valid) last_q <= head;
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (push) q_mem[wr_ptr] <= '{ins: imem_data, pc4: held_pc4};
  end

endmodule

// File: tb/tb_pipe_if_queue.sv
// Bench for pipe_if_queue: behavioural ROM, scoreboard of expected fetch stream,
// table of redirect vectors and hand sequences for stall, latency and reset.
module tb_pipe_if_queue;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;
  logic        stall;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ins, pc4;
  logic        ins_valid;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  psrc;
    logic [31:0] tgt;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
    logic [31:0] e_addr;
  } vec_t;
  vec_t vecs[6];

  pipe_if_queue dut (
    .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .da(da), .jpc(jpc),
    .stall(stall), .imem_addr(imem_addr), .imem_data(imem_data), .ins(ins), .pc4(pc4),
    .ins_valid(ins_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_val(input logic [5:0] a);
    return 32'(a) * 32'h11;
  endfunction

  always @(posedge clock) imem_data <= rom_val(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    logic [31:0] p;
    exp_t e;
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      p = pc + 32'(4 * i);
      e.ins = rom_val(p[7:2]);
      e.pc4 = p + 32'd4;
      sb.push_back(e);
    end
  endtask

  // Compare the head being consumed at the coming edge, then advance one cycle.
  task automatic cyc();
    exp_t e;
    if (resetn && pcsource == 2'b00 && ins_valid && !stall) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_empty: got ins %h with nothing expected", ins);
      end else begin
        e = sb.pop_front();
        chk("stream_ins", ins, e.ins);
        chk("stream_pc4", pc4, e.pc4);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 6 && !ins_valid; k++) cyc();
    chk(name, 32'(k), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{psrc: 2'b01, tgt: 32'h40,       e_ins: 32'h110, e_pc4: 32'h44,  e_addr: 32'd16};
    vecs[1] = '{psrc: 2'b10, tgt: 32'h23,       e_ins: 32'h88,  e_pc4: 32'h24,  e_addr: 32'd8};
    vecs[2] = '{psrc: 2'b11, tgt: 32'h23,       e_ins: 32'h88,  e_pc4: 32'h24,  e_addr: 32'd8};
    vecs[3] = '{psrc: 2'b11, tgt: 32'hFC,       e_ins: 32'h42F, e_pc4: 32'h100, e_addr: 32'd63};
    vecs[4] = '{psrc: 2'b11, tgt: 32'hFFFFFFFC, e_ins: 32'h42F, e_pc4: 32'h0,   e_addr: 32'd63};
    vecs[5] = '{psrc: 2'b01, tgt: 32'h7,        e_ins: 32'h11,  e_pc4: 32'h8,   e_addr: 32'd1};

    resetn = 1'b0; pcsource = 2'b00; bpc = '0; da = '0; jpc = '0; stall = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_pc4", pc4, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Streaming from reset
    resetn = 1'b1;
    sb_restart(32'd0);
    wait_valid("start_latency");
    repeat (8) cyc();

    // Stall from start: queue fills, fetch stops, head is stable
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    stall = 1'b1;
    sb_restart(32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i >= 4) chk("stall_ins", ins, 32'd0);
      cyc();
    end
    chk("stall_valid", 32'(ins_valid), 32'd1);
    chk("stall_pc4", pc4, 32'd4);
    chk("stall_fpc_addr", 32'(imem_addr), 32'd4);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("nogap_valid", 32'(ins_valid), 32'd1);
      cyc();
    end

    // Redirect vectors
    for (int v = 0; v < 6; v++) begin
      stall = 1'b1;
      repeat (3) cyc();
      bpc = 32'hDEADBEE0; da = 32'hCAFEF00C; jpc = 32'h12345678;
      case (vecs[v].psrc)
        2'b01:   bpc = vecs[v].tgt;
        2'b10:   da  = vecs[v].tgt;
        default: jpc = vecs[v].tgt;
      endcase
      pcsource = vecs[v].psrc;
      stall = 1'b0;
      cyc();
      pcsource = 2'b00; bpc = '0; da = '0; jpc = '0;
      sb_restart(vecs[v].tgt & ~32'd3);
      chk("redir_flush", 32'(ins_valid), 32'd0);
      chk("redir_addr", 32'(imem_addr), vecs[v].e_addr);
      wait_valid("redir_latency");
      chk("redir_ins", ins, vecs[v].e_ins);
      chk("redir_pc4", pc4, vecs[v].e_pc4);
      repeat (6) cyc();
    end

    // Reset mid-stream
    repeat (3) cyc();
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 32'(ins_valid), 32'd0);
    chk("midrst_ins", ins, 32'd0);
    chk("midrst_pc4", pc4, 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    sb_restart(32'd0);
    wait_valid("midrst_latency");
    repeat (6) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
